// File: rtl/rect_gpu_core.sv
// rect_gpu_core: loads rect descriptors as absolute edges and composites the
// highest-index covering rect's color for the current pixel.
module rect_gpu_core #(
    parameter int          COORD_WIDTH      = 16,
    parameter int          RECT_COUNT       = 64,
    parameter int          RECT_COUNT_WIDTH = 6,
    parameter logic [15:0] DEFAULT_COLOR    = 16'h0000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   copy_start,
    input  logic [COORD_WIDTH-1:0] x_coord,
    input  logic [COORD_WIDTH-1:0] y_coord,
    input  logic [15:0]            mem_din,
    output logic [15:0]            color
);
    typedef enum logic [1:0] {WAIT, COPY, EXECUTE} state_t;
    typedef enum logic [2:0] {ST_START, ST_X, ST_Y, ST_W, ST_H, ST_COLOR} step_t;

    state_t state, state_next;
    step_t step, step_next;
    logic [RECT_COUNT_WIDTH-1:0] counter, counter_next;

    logic [COORD_WIDTH-1:0] left   [RECT_COUNT] = '{default: '0};
    logic [COORD_WIDTH-1:0] top    [RECT_COUNT] = '{default: '0};
    logic [COORD_WIDTH-1:0] right  [RECT_COUNT] = '{default: '0};
    logic [COORD_WIDTH-1:0] bottom [RECT_COUNT] = '{default: '0};
    logic [15:0]            rect_color [RECT_COUNT] = '{default: '0};

    logic [COORD_WIDTH-1:0] din;
    logic                   last_word;
    logic [RECT_COUNT-1:0]  hit;

    assign din = mem_din[COORD_WIDTH-1:0];
    assign last_word = state == COPY && step == ST_COLOR;

    always_comb begin
        state_next = state;
        if (state == WAIT && copy_start)
            state_next = COPY;
        else if (last_word && counter == RECT_COUNT_WIDTH'(RECT_COUNT - 1))
            state_next = EXECUTE;
        step_next = (state != COPY || step == ST_COLOR) ? ST_START : step_t'(step + 3'd1);
        counter_next = state == WAIT ? '0 : last_word ? counter + 1'b1 : counter;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= WAIT;
            step    <= ST_START;
            counter <= '0;
        end else begin
            state   <= state_next;
            step    <= step_next;
            counter <= counter_next;
        end
    end

    // Storage is deliberately not cleared by reset; an aborted load keeps what it wrote.
    always_ff @(posedge clk) begin
        if (state == COPY) begin
            if (step == ST_X) left[counter] <= din;
            if (step == ST_Y) top[counter] <= din;
            if (step == ST_W) right[counter] <= din + left[counter];
            if (step == ST_H) bottom[counter] <= din + top[counter];
            if (step == ST_COLOR) rect_color[counter] <= mem_din;
        end
    end

    for (genvar i = 0; i < RECT_COUNT; i++) begin : g_hit
        assign hit[i] = x_coord >= left[i] && x_coord < right[i] &&
                        y_coord >= top[i] && y_coord < bottom[i];
    end

    // Priority tree: each level halves the candidates, the odd (higher) child wins on hit.
    for (genvar l = 0; l <= RECT_COUNT_WIDTH; l++) begin : lv
        logic [(RECT_COUNT >> l)-1:0] h;
        logic [RECT_COUNT_WIDTH-1:0]  idx [RECT_COUNT >> l];
        for (genvar i = 0; i < (RECT_COUNT >> l); i++) begin : g_node
            if (l == 0) begin : g_leaf
                assign h[i]   = hit[i];
                assign idx[i] = RECT_COUNT_WIDTH'(i);
            end else begin : g_inner
                assign h[i]   = lv[l-1].h[2*i] | lv[l-1].h[2*i+1];
                assign idx[i] = lv[l-1].h[2*i+1] ? lv[l-1].idx[2*i+1] : lv[l-1].idx[2*i];
            end
        end
    end

    assign color = lv[RECT_COUNT_WIDTH].h[0] ? rect_color[lv[RECT_COUNT_WIDTH].idx[0]] : DEFAULT_COLOR;
endmodule

// File: tb/tb_rect_gpu_core.sv
// tb_rect_gpu_core: streams rect sets into rect_gpu_core and checks pixel colors
// against expected values queued as each probe is driven.
module tb_rect_gpu_core;
    logic        clk = 0, reset = 1, copy_start = 0;
    logic [15:0] x_coord = 0, y_coord = 0, mem_din = 0;
    logic [15:0] color;
    int n_chk = 0, n_pass = 0;
    int rx [64], ry [64], rw [64], rh [64], rc [64];
    logic [15:0] sb [$];

    always #5 clk = ~clk;

    rect_gpu_core dut (
        .clk(clk), .reset(reset), .copy_start(copy_start),
        .x_coord(x_coord), .y_coord(y_coord), .mem_din(mem_din), .color(color)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic clear_rects();
        for (int i = 0; i < 64; i++) begin
            rx[i] = 0; ry[i] = 0; rw[i] = 0; rh[i] = 0; rc[i] = 0;
        end
    endtask

    task automatic set_rect(input int i, input int x, input int y, input int w, input int h, input int c);
        rx[i] = x; ry[i] = y; rw[i] = w; rh[i] = h; rc[i] = c;
    endtask

    task automatic do_reset();
        @(negedge clk) reset = 1;
        @(negedge clk) reset = 0;
    endtask

    // Streams the bench rect table; abort >= 0 asserts reset after that many load cycles.
    task automatic load(input int abort);
        int cyc = 0;
        @(negedge clk) copy_start = 1;
        @(negedge clk) copy_start = 0;
        for (int n = 0; n < 64; n++) begin
            for (int k = 0; k < 6; k++) begin
                if (cyc == abort) begin
                    reset = 1;
                    @(negedge clk) reset = 0;
                    return;
                end
                mem_din = k == 0 ? 16'($urandom) : k == 1 ? 16'(rx[n]) : k == 2 ? 16'(ry[n]) :
                          k == 3 ? 16'(rw[n]) : k == 4 ? 16'(rh[n]) : 16'(rc[n]);
                cyc++;
                @(negedge clk);
            end
        end
        @(negedge clk);
    endtask

    task automatic probe(input string tag, input int x, input int y, input logic [15:0] exp);
        x_coord = 16'(x);
        y_coord = 16'(y);
        sb.push_back(exp);
        #1;
        check(tag, color, sb.pop_front());
    endtask

    task automatic probe_overlap(input string tag);
        probe({tag, "_inner"}, 55, 55, 16'h07E0);
        probe({tag, "_outer"}, 10, 10, 16'h001F);
        probe({tag, "_corner"}, 99, 99, 16'h001F);
        probe({tag, "_outside"}, 100, 50, 16'h0000);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        reset = 0;
        check("reset_state", dut.state, 0);
        check("reset_counter", dut.counter, 0);
        clear_rects();
        load(-1);
        check("zeros_execute", dut.state, 2);
        check("zeros_counter_wrap", dut.counter, 0);
        probe("zeros_origin", 0, 0, 16'h0000);

        do_reset();
        set_rect(0, 10, 20, 5, 5, 16'hF800);
        load(-1);
        probe("r0_topleft", 10, 20, 16'hF800);
        probe("r0_botright", 14, 24, 16'hF800);
        probe("r0_right_excl", 15, 20, 16'h0000);
        probe("r0_bottom_excl", 10, 25, 16'h0000);
        probe("r0_left_out", 9, 20, 16'h0000);

        do_reset();
        clear_rects();
        set_rect(3, 0, 0, 100, 100, 16'h001F);
        set_rect(40, 50, 50, 10, 10, 16'h07E0);
        load(-1);
        probe_overlap("ovl");

        do_reset();
        set_rect(63, 0, 0, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        load(-1);
        probe("r63_origin", 0, 0, 16'hFFFF);
        probe("r63_inner", 55, 55, 16'hFFFF);
        probe("r63_far", 16'hFFFE, 16'hFFFE, 16'hFFFF);
        probe("r63_excl", 16'hFFFF, 0, 16'h0000);

        @(negedge clk) copy_start = 1;
        @(negedge clk) copy_start = 0;
        for (int i = 0; i < 60; i++) begin
            mem_din = 16'($urandom);
            @(negedge clk);
        end
        check("exec_sticky", dut.state, 2);
        probe("exec_noreload", 1234, 777, 16'hFFFF);

        do_reset();
        clear_rects();
        set_rect(3, 0, 0, 100, 100, 16'h001F);
        set_rect(40, 50, 50, 10, 10, 16'h07E0);
        load(100);
        check("abort_state", dut.state, 0);
        check("abort_counter", dut.counter, 0);
        load(-1);
        check("reload_execute", dut.state, 2);
        probe_overlap("reload");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end
endmodule
